crossing_sequencer: RTL and testbench

//  Master FSM of the train controller: sequences the level crossing (startup, warn, gate close,

---
 rtl/train_pkg.sv | 26 ++
 rtl/ms_countdown.sv | 31 +++
 rtl/crossing_sequencer.sv | 65 ++++++
 tb/tb_crossing_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// train_pkg: state codes, per-state durations and timing helpers for the level-crossing sequencer
package train_pkg;
  localparam int DEF_T_WIDTH = 19;
  localparam int D_STARTUP_MS = 2000;
  localparam int D_WARN_MS = 1000;
  localparam int D_HOLD_MS = 2000;
  typedef enum logic [3:0] {
    ST_STARTUP = 4'b0000,
    ST_WAIT    = 4'b0001,
    ST_CLOSE   = 4'b0010,
    ST_WARN    = 4'b0011,
    ST_HOLD    = 4'b0100,
    ST_OPEN    = 4'b0101,
    ST_OCCUPY  = 4'b0110,
    ST_FAULT   = 4'b1111
  } state_t;
  function automatic int dur_ms(state_t s, int gate_ms);
    return s == ST_STARTUP ? D_STARTUP_MS :
           s == ST_WARN    ? D_WARN_MS :
           s == ST_HOLD    ? D_HOLD_MS :
           (s == ST_CLOSE || s == ST_OPEN) ? gate_ms : 0;
  endfunction
  function automatic logic is_timed(state_t s);
    return s inside {ST_STARTUP, ST_WARN, ST_CLOSE, ST_HOLD, ST_OPEN};
  endfunction
endpackage

// File: rtl/ms_countdown.sv
// ms_countdown: millisecond prescaler plus loadable down-counter that saturates at zero
module ms_countdown #(
  parameter int TICK_DIV = 50000,
  parameter int T_WIDTH = 19,
  parameter logic [T_WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [T_WIDTH-1:0] load_val,
  input  logic               run,
  output logic [T_WIDTH-1:0] remaining,
  output logic               expired
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc;
  logic tick;
  assign tick = run && presc == PW'(TICK_DIV - 1);
  assign expired = run && remaining == '0;
  always_ff @(posedge clk)
    if (rst) begin
      presc <= '0;
      remaining <= RST_VAL;
    end else if (load) begin
      presc <= '0;
      remaining <= load_val;
    end else begin
      presc <= !run || tick ? '0 : presc + 1'b1;
      remaining <= tick && remaining != '0 ? remaining - 1'b1 : remaining;
    end
endmodule

// File: rtl/crossing_sequencer.sv
// crossing_sequencer: master FSM sequencing the level crossing with ms-timed states and Moore outputs
module crossing_sequencer
  import train_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int T_WIDTH = DEF_T_WIDTH,
  parameter int GATE_TIMEOUT_MS = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               train_approach,
  input  logic               train_clear,
  input  logic               gate_closed,
  input  logic               gate_open,
  input  logic               fault_clr,
  output logic [3:0]         present_state,
  output logic               gate_cmd,
  output logic               light_on,
  output logic               alarm,
  output logic [T_WIDTH-1:0] t_remaining
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  state_t state, nxt;
  logic expired;
  assign present_state = state;
  ms_countdown #(
    .TICK_DIV(TICK_DIV),
    .T_WIDTH(T_WIDTH),
    .RST_VAL(T_WIDTH'(D_STARTUP_MS))
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .load(nxt != state),
    .load_val(T_WIDTH'(dur_ms(nxt, GATE_TIMEOUT_MS))),
    .run(is_timed(state)),
    .remaining(t_remaining),
    .expired(expired)
  );
  always_comb begin
    nxt = state;
    case (state)
      ST_STARTUP: nxt = expired ? ST_WAIT : ST_STARTUP;
      ST_WAIT:    nxt = train_approach ? ST_WARN : ST_WAIT;
      ST_WARN:    nxt = expired ? ST_CLOSE : ST_WARN;
      ST_CLOSE:   nxt = gate_closed ? ST_OCCUPY : expired ? ST_FAULT : ST_CLOSE;
      ST_OCCUPY:  nxt = train_clear ? ST_HOLD : ST_OCCUPY;
      ST_HOLD:    nxt = train_approach ? ST_OCCUPY : expired ? ST_OPEN : ST_HOLD;
      ST_OPEN:    nxt = gate_open ? ST_WAIT : expired ? ST_FAULT : ST_OPEN;
      ST_FAULT:   nxt = fault_clr ? ST_STARTUP : ST_FAULT;
      default:    nxt = ST_FAULT;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_STARTUP;
      gate_cmd <= 1'b1;
      light_on <= 1'b1;
      alarm <= 1'b0;
    end else begin
      state <= nxt;
      gate_cmd <= nxt inside {ST_STARTUP, ST_CLOSE, ST_OCCUPY, ST_HOLD, ST_FAULT};
      light_on <= nxt inside {ST_STARTUP, ST_WARN, ST_CLOSE, ST_OCCUPY, ST_HOLD, ST_FAULT};
      alarm <= nxt == ST_FAULT;
    end
endmodule

// File: tb/tb_crossing_sequencer.sv
// tb_crossing_sequencer: directed and random stimulus against a cycle-count reference model
module tb_crossing_sequencer;
  localparam int TD = 4;
  localparam int GT = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic train_approach = 1'b0;
  logic train_clear = 1'b0;
  logic gate_closed = 1'b0;
  logic gate_open = 1'b0;
  logic fault_clr = 1'b0;
  logic [3:0] present_state;
  logic gate_cmd, light_on, alarm;
  logic [18:0] t_remaining;
  int n_checks = 0;
  int n_fail = 0;
  int m_st = 0;
  int m_cyc = 0;
  crossing_sequencer #(
    .CLK_HZ(4000),
    .T_WIDTH(19),
    .GATE_TIMEOUT_MS(GT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .train_approach(train_approach),
    .train_clear(train_clear),
    .gate_closed(gate_closed),
    .gate_open(gate_open),
    .fault_clr(fault_clr),
    .present_state(present_state),
    .gate_cmd(gate_cmd),
    .light_on(light_on),
    .alarm(alarm),
    .t_remaining(t_remaining)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int dur(input int s);
    case (s)
      0, 4: return 2000;
      3: return 1000;
      2, 5: return GT;
      default: return 0;
    endcase
  endfunction
  function automatic int model_next(input int s, input int cyc, input logic a, c, gc, go, fc);
    bit ex;
    ex = dur(s) > 0 && cyc == dur(s) * TD;
    case (s)
      0: return ex ? 1 : 0;
      1: return a ? 3 : 1;
      3: return ex ? 2 : 3;
      2: return gc ? 6 : ex ? 15 : 2;
      6: return c ? 4 : 6;
      4: return a ? 6 : ex ? 5 : 4;
      5: return go ? 1 : ex ? 15 : 5;
      default: return fc ? 0 : 15;
    endcase
  endfunction
  task automatic step(input logic a, c, gc, go, fc, r);
    int n;
    train_approach = a;
    train_clear = c;
    gate_closed = gc;
    gate_open = go;
    fault_clr = fc;
    rst = r;
    if (r) begin
      m_st = 0;
      m_cyc = 0;
    end else begin
      n = model_next(m_st, m_cyc, a, c, gc, go, fc);
      m_cyc = n == m_st ? m_cyc + 1 : 0;
      m_st = n;
    end
    @(posedge clk);
    #1;
    check("state", present_state, m_st);
    check("t_remaining", t_remaining, dur(m_st) > 0 ? dur(m_st) - m_cyc / TD : 0);
    check("gate_cmd", gate_cmd, int'(m_st inside {0, 2, 4, 6, 15}));
    check("light_on", light_on, int'(m_st inside {0, 2, 3, 4, 6, 15}));
    check("alarm", alarm, int'(m_st == 15));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1);
    check("rst_state", present_state, 0);
    check("rst_t", t_remaining, 2000);
    check("rst_gate", gate_cmd, 1);
    idle(8000);
    check("startup_hold", present_state, 0);
    idle(1);
    check("startup_exit", present_state, 1);
    step(1, 0, 0, 0, 0, 0);
    check("warn_entry", present_state, 3);
    idle(4000);
    check("warn_hold", present_state, 3);
    idle(1);
    check("close_entry", present_state, 2);
    step(0, 0, 1, 0, 0, 0);
    check("occupy", present_state, 6);
    step(0, 1, 0, 0, 0, 0);
    check("hold_entry", present_state, 4);
    idle(8001);
    check("open_entry", present_state, 5);
    check("open_gate", gate_cmd, 0);
    step(0, 0, 0, 1, 0, 0);
    check("wait_again", present_state, 1);
    check("wait_light", light_on, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(4001);
    check("close2", present_state, 2);
    idle(40);
    check("close_no_fault_yet", present_state, 2);
    idle(1);
    check("fault", present_state, 15);
    check("fault_alarm", alarm, 1);
    step(0, 0, 0, 0, 1, 0);
    check("fault_clr", present_state, 0);
    check("fault_clr_alarm", alarm, 0);
    idle(8001);
    step(1, 0, 0, 0, 0, 0);
    idle(4001);
    idle(40);
    check("close_expiry_cycle", t_remaining, 0);
    step(0, 0, 1, 0, 0, 0);
    check("close_tie", present_state, 6);
    step(0, 1, 0, 0, 0, 0);
    idle(6000);
    check("hold_500", t_remaining, 500);
    step(1, 0, 0, 0, 0, 0);
    check("hold_reoccupy", present_state, 6);
    step(0, 1, 0, 0, 0, 0);
    check("hold_reload_state", present_state, 4);
    check("hold_reload_t", t_remaining, 2000);
    idle(8001);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(101);
    step(0, 0, 0, 0, 0, 1);
    check("rst_mid_state", present_state, 0);
    check("rst_mid_t", t_remaining, 2000);
    idle(8000);
    check("rst_mid_hold", present_state, 0);
    idle(1);
    check("rst_mid_exit", present_state, 1);
    for (int i = 0; i < 12000; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 5, $urandom_range(0, 4999) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
